ysyx_lsu_sram: RTL and testbench
================================

# ysyx_lsu_sram

Memory-side responder for the LSU load/store bus. It accepts one load request (araddr/arvalid/rstrb) or one store request (awaddr/awvalid/wdata/wstrb/wvalid) at a time and serves it from an internal word-organised SRAM after a fixed, parameterised latency. It answers with a one-cycle rvalid or wready pulse. It sits between the LSU and the system bus and is used both as a standalone data memory and as a latency model when verifying the LSU and its L1D.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (one word, four byte lanes)
- MEM_BASE, 32'h8000_0000, byte address of word 0
- MEM_WORDS, 1024, SRAM depth in words (power of two)
- LATENCY, 2, cycles from request accept to response pulse; legal range is 1..15
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- lsu_araddr  in  ADDR_W  load byte address
- lsu_arvalid  in  1  load request; held high by the LSU until rvalid
- lsu_rstrb  in  8  load byte mask; informational only, the full word is always returned
- lsu_rdata_o  out  DATA_W  aligned word containing araddr; meaningful only while rvalid is high
- lsu_rvalid_o  out  1  load response pulse
- lsu_awaddr  in  ADDR_W  store byte address
- lsu_awvalid  in  1  store address valid
- lsu_wdata  in  DATA_W  store data, LSB-justified (not pre-shifted)
- lsu_wstrb  in  8  store mask, LSB-justified: 8'h1, 8'h3 or 8'hf
- lsu_wvalid  in  1  store data valid
- lsu_wready_o  out  1  store completion pulse

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, RESP.
- **IDLE, accepting requests:**
  - A store is accepted when awvalid & wvalid are both high. Capture awaddr, wdata and wstrb, load cnt = LATENCY-1, and go to WR_WAIT.
  - Otherwise a load is accepted when arvalid is high. Capture araddr, load cnt = LATENCY-1, and go to RD_WAIT.
  - If store and load are both requested in the same cycle, the store wins. The load stays pending because the LSU keeps arvalid high.
  - awvalid without wvalid (or the reverse) is not accepted; stay in IDLE.
- **RD_WAIT / WR_WAIT:** decrement cnt each cycle. When cnt == 0, perform the access and go to RESP.
- **RESP:** exactly one cycle with rvalid_o or wready_o high, then return to IDLE. No request is accepted in RESP, so there is at least one idle cycle between responses. This gives the LSU time to drop arvalid/awvalid.
- Address decode:
  - in_range = (addr >= MEM_BASE) && (addr < MEM_BASE + 4*MEM_WORDS).
  - index = (addr - MEM_BASE) >> 2, truncated to log2(MEM_WORDS) bits.
- **Read:**
  - rdata_o = mem[index], the whole aligned word with no shifting. The LSU does lane extraction using addr[1:0].
  - An out-of-range read returns 32'h0 and still pulses rvalid.
- **Write:**
  - lane mask = (wstrb[3:0] << awaddr[1:0]) & 4'hf.
  - Shifted data = wdata << (8*awaddr[1:0]).
  - Only the enabled bytes of mem[index] change. Lanes shifted past byte 3 are dropped; misaligned halfwords and words are not split across words.
  - An out-of-range write changes nothing and still pulses wready.
- Read data is sampled from the SRAM in the cycle the access is performed (cnt == 0), not at accept. A store that completed earlier is always visible.

## Timing
- Reset values: state = IDLE, cnt = 0, rvalid_o = 0, wready_o = 0, rdata_o = 0. The SRAM contents are not cleared by reset.
- **Load latency:**
  - A request accepted at the rising edge of cycle t produces rvalid_o high during cycle t+LATENCY+1, with rdata_o valid in the same cycle.
  - LATENCY=1: accept edge t, access edge t+1, rvalid high in cycle t+1 → t+2.
- **Store latency:** the SRAM is updated at edge t+LATENCY, and wready_o is high for the following cycle.
- rdata_o holds its last value after the rvalid pulse. It changes only when a read access is performed, or on reset.
- Back-to-back throughput: one request per LATENCY+2 cycles.
- Reset asserted while in RD_WAIT, WR_WAIT or RESP:
  - return to IDLE on the next edge;
  - no pulse is generated;
  - a write not yet performed is discarded, and one already performed stays in memory.
- Inputs change during WAIT: the captured address and data are used; live inputs are ignored until IDLE.
- cnt width is 4 bits; LATENCY outside 1..15 is unsupported.

## Test plan
- **Reset:** hold rst for 3 cycles while driving arvalid=1. Required: rvalid_o=0, wready_o=0, rdata_o=0 throughout; the first rvalid_o appears LATENCY+1 cycles after rst is released.
- **SW then LW:**
  - Store wdata=32'hdeadbeef, wstrb=8'hf at 0x8000_0010.
  - Then load from 0x8000_0010.
  - Required: one wready pulse, then rdata_o=32'hdeadbeef with a single-cycle rvalid exactly LATENCY+1 cycles after the load is accepted.
- **Sub-word stores:**
  - Preload 0x8000_0020 with 32'h11223344.
  - SB wdata=8'hAA at 0x8000_0021, then SH wdata=16'hBBCC at 0x8000_0022.
  - Required: the load of 0x8000_0020 returns 32'hBBCCAA44. A SH at 0x8000_0023 changes only byte 3.
- **Out of range:**
  - Load from 0x0000_0100. Required: rdata_o=0 with an rvalid pulse.
  - Store to 0x8000_1000 (one past the end with MEM_WORDS=1024). Required: wready pulses, and the contents of word 0 and word 1023 are unchanged.
- **Simultaneous requests:**
  - Assert arvalid and awvalid/wvalid together, with the store to address A carrying 32'h5a5a5a5a and the load also from A.
  - Required: the store is served first; the load is accepted after the RESP cycle and returns 32'h5a5a5a5a.
- **Reset mid-operation:**
  - With LATENCY=4, accept a store of 32'h12345678 to 0x8000_0040 (previously 0), and pulse rst two cycles later.
  - Required: no wready pulse, and a subsequent load returns 0.
- Repeat all scenarios with LATENCY=1 and LATENCY=15.

Source files
------------

// File: rtl/ysyx_lsu_sram.sv
// ysyx_lsu_sram: fixed-latency word SRAM responder for the LSU load/store bus
module ysyx_lsu_sram #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_rvalid_o,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready_o
);
  localparam int IW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q, off;
  logic [DATA_W-1:0] wdata_q, wsh;
  logic [3:0] wstrb_q, lane;
  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic st_req, accept, in_range, rd_do, wr_do, unused_bits;
  logic [IW-1:0] idx;
  assign unused_bits = ^{lsu_rstrb, lsu_wstrb[7:4]};
  assign st_req   = lsu_awvalid & lsu_wvalid;
  assign accept   = (state == IDLE) && (st_req || lsu_arvalid);
  assign off      = addr_q - MEM_BASE;
  // offset compare avoids overflow of MEM_BASE + size near the top of the address space
  assign in_range = (addr_q >= MEM_BASE) && (off < ADDR_W'(4 * MEM_WORDS));
  assign idx      = off[IW+1:2];
  assign rd_do    = (state == RD_WAIT) && (cnt == 4'd0);
  assign wr_do    = (state == WR_WAIT) && (cnt == 4'd0);
  assign lane     = wstrb_q << addr_q[1:0];
  assign wsh      = wdata_q << {addr_q[1:0], 3'b000};
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        state_n = st_req ? WR_WAIT : lsu_arvalid ? RD_WAIT : IDLE;
        cnt_n   = accept ? 4'(LATENCY - 1) : cnt;
      end
      RD_WAIT, WR_WAIT: begin
        state_n = (cnt == 4'd0) ? RESP : state;
        cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lsu_rvalid_o <= 1'b0;
      lsu_wready_o <= 1'b0;
      lsu_rdata_o  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lsu_rvalid_o <= rd_do;
      lsu_wready_o <= wr_do;
      if (rd_do) lsu_rdata_o <= in_range ? mem[idx] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= st_req ? lsu_awaddr : lsu_araddr;
      wdata_q <= lsu_wdata;
      wstrb_q <= lsu_wstrb[3:0];
    end
  end
  // SRAM contents survive reset; only a write already reaching its access cycle lands
  always_ff @(posedge clk) begin
    if (!rst && wr_do && in_range)
      for (int b = 0; b < 4; b++)
        if (lane[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
  end
endmodule

// File: tb/tb_ysyx_lsu_sram.sv
// tb_ysyx_lsu_sram: table-driven check of four latency variants of ysyx_lsu_sram
module tb_ysyx_lsu_sram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst [4];
  logic [31:0] araddr [4], awaddr [4], wdata [4], rdata [4];
  logic [7:0]  rstrb [4], wstrb [4];
  logic        arvalid [4], awvalid [4], wvalid [4], rvalid [4], wready [4];
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : d
      ysyx_lsu_sram #(.LATENCY(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 15)) u (
        .clk(clk), .rst(rst[g]),
        .lsu_araddr(araddr[g]), .lsu_arvalid(arvalid[g]), .lsu_rstrb(rstrb[g]),
        .lsu_rdata_o(rdata[g]), .lsu_rvalid_o(rvalid[g]),
        .lsu_awaddr(awaddr[g]), .lsu_awvalid(awvalid[g]), .lsu_wdata(wdata[g]),
        .lsu_wstrb(wstrb[g]), .lsu_wvalid(wvalid[g]), .lsu_wready_o(wready[g]));
    end
  endgenerate
  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tv [18];
  int n_cmp = 0, n_bad = 0;
  function automatic int lat(int k);
    return k == 0 ? 1 : k == 1 ? 2 : k == 2 ? 4 : 15;
  endfunction
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (LATENCY=%0d): got %h, expected %h", nm, lat(k), act, exp);
    end
  endtask
  task automatic wait_pulse(int k, bit rd, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd ? rvalid[k] : wready[k]) && n < 60);
  endtask
  task automatic drop(int k);
    arvalid[k] = 1'b0;
    awvalid[k] = 1'b0;
    wvalid[k]  = 1'b0;
  endtask
  task automatic op(int k, vec_t v);
    int n;
    if (v.st) begin
      awaddr[k] = v.addr; wdata[k] = v.data; wstrb[k] = v.strb;
      awvalid[k] = 1'b1; wvalid[k] = 1'b1;
    end else begin
      araddr[k] = v.addr; rstrb[k] = 8'hff; arvalid[k] = 1'b1;
    end
    wait_pulse(k, !v.st, n);
    chk(v.st ? "store_latency" : "load_latency", k, 32'(n), 32'(lat(k) + 1));
    if (!v.st) chk($sformatf("rdata@%h", v.addr), k, rdata[k], v.exp);
    drop(k);
    @(negedge clk);
    chk("pulse_width", k, {31'b0, v.st ? wready[k] : rvalid[k]}, 32'h0);
  endtask
  initial begin
    int n, seen;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; drop(k);
      araddr[k] = '0; awaddr[k] = '0; wdata[k] = '0; rstrb[k] = '0; wstrb[k] = '0;
    end
    tv[0]  = '{1, 32'h8000_0010, 32'hdeadbeef, 8'hf, 32'h0};
    tv[1]  = '{0, 32'h8000_0010, 32'h0, 8'h0, 32'hdeadbeef};
    tv[2]  = '{0, 32'h8000_0012, 32'h0, 8'h0, 32'hdeadbeef};
    tv[3]  = '{1, 32'h8000_0020, 32'h11223344, 8'hf, 32'h0};
    tv[4]  = '{1, 32'h8000_0021, 32'h000000aa, 8'h1, 32'h0};
    tv[5]  = '{1, 32'h8000_0022, 32'h0000bbcc, 8'h3, 32'h0};
    tv[6]  = '{0, 32'h8000_0020, 32'h0, 8'h0, 32'hbbccaa44};
    tv[7]  = '{1, 32'h8000_0023, 32'h0000ddee, 8'h3, 32'h0};
    tv[8]  = '{0, 32'h8000_0020, 32'h0, 8'h0, 32'heeccaa44};
    tv[9]  = '{0, 32'h0000_0100, 32'h0, 8'h0, 32'h0};
    tv[10] = '{0, 32'h7fff_fffc, 32'h0, 8'h0, 32'h0};
    tv[11] = '{1, 32'h8000_0000, 32'h01010101, 8'hf, 32'h0};
    tv[12] = '{1, 32'h8000_0ffc, 32'h0ff0ffc0, 8'hf, 32'h0};
    tv[13] = '{1, 32'h8000_1000, 32'hffffffff, 8'hf, 32'h0};
    tv[14] = '{0, 32'h8000_0000, 32'h0, 8'h0, 32'h01010101};
    tv[15] = '{0, 32'h8000_0ffc, 32'h0, 8'h0, 32'h0ff0ffc0};
    tv[16] = '{0, 32'h8000_1000, 32'h0, 8'h0, 32'h0};
    tv[17] = '{1, 32'h8000_0040, 32'h0, 8'hf, 32'h0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      araddr[k] = 32'h0000_0100; arvalid[k] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("reset_rvalid", k, {31'b0, rvalid[k]}, 32'h0);
        chk("reset_wready", k, {31'b0, wready[k]}, 32'h0);
        chk("reset_rdata", k, rdata[k], 32'h0);
      end
      rst[k] = 1'b0;
      wait_pulse(k, 1'b1, n);
      chk("first_rvalid_latency", k, 32'(n), 32'(lat(k) + 1));
      drop(k);
      @(negedge clk);
      foreach (tv[i]) op(k, tv[i]);
      awaddr[k] = 32'h8000_0080; wdata[k] = 32'h5a5a5a5a; wstrb[k] = 8'hf;
      araddr[k] = 32'h8000_0080;
      awvalid[k] = 1'b1; wvalid[k] = 1'b1; arvalid[k] = 1'b1;
      wait_pulse(k, 1'b0, n);
      chk("simul_store_latency", k, 32'(n), 32'(lat(k) + 1));
      chk("simul_no_early_rvalid", k, {31'b0, rvalid[k]}, 32'h0);
      awvalid[k] = 1'b0; wvalid[k] = 1'b0;
      wait_pulse(k, 1'b1, n);
      chk("simul_load_latency", k, 32'(n), 32'(lat(k) + 2));
      chk("simul_rdata", k, rdata[k], 32'h5a5a5a5a);
      drop(k);
      @(negedge clk);
      if (lat(k) >= 4) begin
        awaddr[k] = 32'h8000_0040; wdata[k] = 32'h12345678; wstrb[k] = 8'hf;
        awvalid[k] = 1'b1; wvalid[k] = 1'b1;
        seen = 0;
        repeat (2) begin
          @(negedge clk);
          seen += int'(wready[k]);
        end
        rst[k] = 1'b1;
        drop(k);
        @(negedge clk);
        rst[k] = 1'b0;
        repeat (20) begin
          @(negedge clk);
          seen += int'(wready[k]);
        end
        chk("midreset_wready_count", k, 32'(seen), 32'h0);
        op(k, '{0, 32'h8000_0040, 32'h0, 8'h0, 32'h0});
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
